fp_to_int_conv: RTL and testbench

FP_TO_INT_CONV -- requirements
Module: fp_to_int_conv

---
 rtl/fp_conv_pkg.sv | 27 ++
 rtl/fp2i_align_shift.sv | 65 ++++++
 rtl/fp_to_int_conv.sv | 191 +++++++++++++++++++
 tb/tb_fp_to_int_conv.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_conv_pkg.sv
// Shared types and constants for the float-to-integer converter.
package fp_conv_pkg;

  typedef enum logic [1:0] {
    RND_RNE   = 2'd0,
    RND_RTZ   = 2'd1,
    RND_FLOOR = 2'd2,
    RND_CEIL  = 2'd3
  } rnd_mode_e;

  // Bit positions inside flags = {invalid, overflow, inexact, zero}
  localparam int unsigned FLAG_ZERO     = 0;
  localparam int unsigned FLAG_INEXACT  = 1;
  localparam int unsigned FLAG_OVERFLOW = 2;
  localparam int unsigned FLAG_INVALID  = 3;
  localparam int unsigned FLAG_W        = 4;

  function automatic int fp_bias(input int unsigned exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Signed width able to hold the clamped shift range [-(sig_w+1), mag_w]
  function automatic int unsigned fp_shift_w(input int unsigned mag_w, input int unsigned sig_w);
    return $clog2(mag_w + sig_w + 2) + 1;
  endfunction

endpackage

// File: rtl/fp2i_align_shift.sv
// Registered alignment shifter: places the significand on the integer grid and
// keeps guard/sticky for the dropped fraction; big flags magnitudes past MAG_W.
module fp2i_align_shift #(
  parameter int unsigned SIG_W = 8,
  parameter int unsigned MAG_W = 18,
  parameter int unsigned SH_W  = 6
) (
  input  logic                    clk,
  input  logic                    en_i,
  input  logic [SIG_W-1:0]        sig_i,
  input  logic signed [SH_W-1:0]  sh_i,
  output logic [MAG_W-1:0]        mag_o,
  output logic                    guard_o,
  output logic                    sticky_o,
  output logic                    big_o
);

  localparam int unsigned WIDE_W = MAG_W + SIG_W;
  localparam int unsigned RX_W   = 2 * SIG_W + 1;

  logic [WIDE_W-1:0] wide;
  logic [RX_W-1:0]   rx;
  logic [SH_W-1:0]   lsh;
  logic [SH_W-1:0]   rs;
  logic              guard_d;
  logic              sticky_d;

  logic [MAG_W-1:0]  mag_q;
  logic              guard_q;
  logic              sticky_q;
  logic              big_q;

  // Shift amounts arrive pre-clamped, so neither direction can wrap.
  always_comb begin
    wide     = '0;
    rx       = '0;
    lsh      = sh_i;
    rs       = -sh_i;
    guard_d  = 1'b0;
    sticky_d = 1'b0;
    if (!sh_i[SH_W-1]) begin
      wide = WIDE_W'(sig_i) << lsh;
    end else begin
      rx       = {sig_i, {(SIG_W + 1){1'b0}}} >> rs;
      wide     = WIDE_W'(rx[RX_W-1 -: SIG_W]);
      guard_d  = rx[SIG_W];
      sticky_d = |rx[SIG_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      mag_q    <= wide[MAG_W-1:0];
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      big_q    <= |wide[WIDE_W-1:MAG_W];
    end
  end

  assign mag_o    = mag_q;
  assign guard_o  = guard_q;
  assign sticky_o = sticky_q;
  assign big_o    = big_q;

endmodule

// File: rtl/fp_to_int_conv.sv
// Pipelined float-to-integer converter: decode, align, round, saturate/negate.
// All stages advance together whenever the output register can move.
module fp_to_int_conv
  import fp_conv_pkg::*;
#(
  parameter int unsigned EXPONENT_SIZE        = 8,
  parameter int unsigned MANTISSA_SIZE        = 7,
  parameter int unsigned INT_SIZE             = 16,
  parameter int unsigned FIXED_POINT_POSITION = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     sign,
  input  logic [EXPONENT_SIZE-1:0] exponent,
  input  logic [MANTISSA_SIZE-1:0] mantissa,
  input  logic [1:0]               rnd_mode,
  input  logic                     is_unsigned,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INT_SIZE-1:0]      dout,
  output logic [FLAG_W-1:0]        flags
);

  localparam int unsigned SIG_W  = MANTISSA_SIZE + 1;
  localparam int unsigned MAG_W  = INT_SIZE + 2;
  localparam int unsigned SH_W   = fp_shift_w(MAG_W, SIG_W);
  localparam int          BIAS   = fp_bias(EXPONENT_SIZE);
  localparam int          SH_MIN = -int'(SIG_W) - 1;
  localparam int          SH_MAX = int'(MAG_W);

  logic advance;

  logic s1_valid_q, s2_valid_q, s3_valid_q, out_valid_q;
  logic [INT_SIZE-1:0] dout_q;
  logic [FLAG_W-1:0]   flags_q;

  // Stage 1 (decode) registers
  logic                   s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q, s1_uns_q;
  rnd_mode_e              s1_rnd_q;
  logic [SIG_W-1:0]       s1_sig_q;
  logic signed [SH_W-1:0] s1_sh_q;
  logic signed [SH_W-1:0] s1_sh_d;
  int                     sh_full;

  // Stage 2 (align) side-band registers; datapath lives in the shifter
  logic                   s2_sign_q, s2_nan_q, s2_inf_q, s2_zero_q, s2_uns_q;
  rnd_mode_e              s2_rnd_q;
  logic [MAG_W-1:0]       s2_mag;
  logic                   s2_guard, s2_sticky, s2_big;

  // Stage 3 (round) registers
  logic                   s3_sign_q, s3_nan_q, s3_inf_q, s3_zero_q, s3_uns_q;
  logic                   s3_big_q, s3_inexact_q;
  logic [MAG_W:0]         s3_mag_q;
  logic [MAG_W:0]         s3_mag_d;
  logic                   round_up;

  // Stage 4 (saturate/negate) next values
  logic [INT_SIZE-1:0]    dout_d;
  logic [FLAG_W-1:0]      flags_d;
  logic [INT_SIZE-1:0]    mag_lo;
  logic                   ovf;

  assign advance   = ~out_valid_q | out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign flags     = flags_q;

  // Shift that puts the significand LSB at the output LSB, clamped to the useful range.
  always_comb begin
    sh_full = int'(exponent) - BIAS - int'(MANTISSA_SIZE) + int'(FIXED_POINT_POSITION);
    if (sh_full < SH_MIN) begin
      s1_sh_d = SH_W'(SH_MIN);
    end else if (sh_full > SH_MAX) begin
      s1_sh_d = SH_W'(SH_MAX);
    end else begin
      s1_sh_d = SH_W'(sh_full);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      flags_q     <= '0;
    end else if (advance) begin
      s1_valid_q  <= in_valid;
      s2_valid_q  <= s1_valid_q;
      s3_valid_q  <= s2_valid_q;
      out_valid_q <= s3_valid_q;
      if (s3_valid_q) begin
        dout_q  <= dout_d;
        flags_q <= flags_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_sign_q <= sign;
      s1_sig_q  <= {1'b1, mantissa};
      s1_sh_q   <= s1_sh_d;
      s1_nan_q  <= (&exponent) & (|mantissa);
      s1_inf_q  <= (&exponent) & ~(|mantissa);
      s1_zero_q <= ~(|exponent);
      s1_rnd_q  <= rnd_mode_e'(rnd_mode);
      s1_uns_q  <= is_unsigned;

      s2_sign_q <= s1_sign_q;
      s2_nan_q  <= s1_nan_q;
      s2_inf_q  <= s1_inf_q;
      s2_zero_q <= s1_zero_q;
      s2_rnd_q  <= s1_rnd_q;
      s2_uns_q  <= s1_uns_q;

      s3_sign_q    <= s2_sign_q;
      s3_nan_q     <= s2_nan_q;
      s3_inf_q     <= s2_inf_q;
      s3_zero_q    <= s2_zero_q;
      s3_uns_q     <= s2_uns_q;
      s3_big_q     <= s2_big;
      s3_inexact_q <= s2_guard | s2_sticky;
      s3_mag_q     <= s3_mag_d;
    end
  end

  fp2i_align_shift #(
    .SIG_W (SIG_W),
    .MAG_W (MAG_W),
    .SH_W  (SH_W)
  ) u_align (
    .clk      (clk),
    .en_i     (advance),
    .sig_i    (s1_sig_q),
    .sh_i     (s1_sh_q),
    .mag_o    (s2_mag),
    .guard_o  (s2_guard),
    .sticky_o (s2_sticky),
    .big_o    (s2_big)
  );

  // Rounding works on the magnitude; floor/ceil pick direction from the sign.
  always_comb begin
    round_up = 1'b0;
    case (s2_rnd_q)
      RND_RNE:   round_up = s2_guard & (s2_sticky | s2_mag[0]);
      RND_RTZ:   round_up = 1'b0;
      RND_FLOOR: round_up = s2_sign_q & (s2_guard | s2_sticky);
      RND_CEIL:  round_up = ~s2_sign_q & (s2_guard | s2_sticky);
      default:   round_up = 1'b0;
    endcase
    s3_mag_d = (MAG_W + 1)'(s2_mag) + (MAG_W + 1)'(round_up);
  end

  always_comb begin
    dout_d  = '0;
    flags_d = '0;
    ovf     = 1'b0;
    mag_lo  = s3_mag_q[INT_SIZE-1:0];
    if (s3_nan_q) begin
      flags_d[FLAG_INVALID] = 1'b1;
    end else if (!s3_zero_q) begin
      if (s3_uns_q) begin
        if (s3_sign_q) begin
          // Negative inputs only survive in unsigned mode when they round to zero
          ovf = s3_inf_q | s3_big_q | (|s3_mag_q);
        end else begin
          ovf    = s3_inf_q | s3_big_q | (|s3_mag_q[MAG_W:INT_SIZE]);
          dout_d = ovf ? {INT_SIZE{1'b1}} : mag_lo;
        end
      end else if (s3_sign_q) begin
        ovf = s3_inf_q | s3_big_q | (|s3_mag_q[MAG_W:INT_SIZE])
            | (s3_mag_q[INT_SIZE-1] & (|s3_mag_q[INT_SIZE-2:0]));
        dout_d = ovf ? {1'b1, {(INT_SIZE - 1){1'b0}}} : INT_SIZE'(0) - mag_lo;
      end else begin
        ovf    = s3_inf_q | s3_big_q | (|s3_mag_q[MAG_W:INT_SIZE-1]);
        dout_d = ovf ? {1'b0, {(INT_SIZE - 1){1'b1}}} : mag_lo;
      end
      flags_d[FLAG_OVERFLOW] = ovf;
      flags_d[FLAG_INEXACT]  = s3_inexact_q & ~ovf;
    end
    flags_d[FLAG_ZERO] = ~(|dout_d) & ~flags_d[FLAG_INVALID];
  end

endmodule

// File: tb/tb_fp_to_int_conv.sv
// Directed bench for fp_to_int_conv with bfloat16 defaults.
module tb_fp_to_int_conv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign;
  logic [7:0]  exponent;
  logic [6:0]  mantissa;
  logic [1:0]  rnd_mode;
  logic        is_unsigned;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dout;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [6:0]  m;
    logic [1:0]  r;
    logic        u;
    logic [15:0] d;
    logic [3:0]  f;
    string       name;
  } vec_t;

  always #5 clk = ~clk;

  fp_to_int_conv dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sign        (sign),
    .exponent    (exponent),
    .mantissa    (mantissa),
    .rnd_mode    (rnd_mode),
    .is_unsigned (is_unsigned),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dout        (dout),
    .flags       (flags)
  );

  // Push one word into an idle pipeline and return what emerges; entered at posedge+1.
  task automatic run_word(input vec_t v, output logic [15:0] d, output logic [3:0] f,
                          output int lat);
    sign = v.s; exponent = v.e; mantissa = v.m; rnd_mode = v.r; is_unsigned = v.u;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    d = dout; f = flags;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (dout !== 16'h0000) begin n_fail++; $display("FAIL reset dout: got %h want 0000", dout); end
    n_checks++;
    if (flags !== 4'b0000) begin n_fail++; $display("FAIL reset flags: got %b want 0000", flags); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_rounding;
    vec_t v[$];
    logic [15:0] d; logic [3:0] f; int lat;
    v.push_back('{1'b0, 8'h80, 7'h20, 2'd0, 1'b0, 16'h0002, 4'b0010, "2.5 rne"});
    v.push_back('{1'b0, 8'h80, 7'h20, 2'd1, 1'b0, 16'h0002, 4'b0010, "2.5 rtz"});
    v.push_back('{1'b0, 8'h80, 7'h20, 2'd2, 1'b0, 16'h0002, 4'b0010, "2.5 floor"});
    v.push_back('{1'b0, 8'h80, 7'h20, 2'd3, 1'b0, 16'h0003, 4'b0010, "2.5 ceil"});
    v.push_back('{1'b1, 8'h80, 7'h20, 2'd0, 1'b0, 16'hFFFE, 4'b0010, "-2.5 rne"});
    v.push_back('{1'b1, 8'h80, 7'h20, 2'd1, 1'b0, 16'hFFFE, 4'b0010, "-2.5 rtz"});
    v.push_back('{1'b1, 8'h80, 7'h20, 2'd2, 1'b0, 16'hFFFD, 4'b0010, "-2.5 floor"});
    v.push_back('{1'b1, 8'h80, 7'h20, 2'd3, 1'b0, 16'hFFFE, 4'b0010, "-2.5 ceil"});
    v.push_back('{1'b0, 8'h7F, 7'h40, 2'd0, 1'b0, 16'h0002, 4'b0010, "1.5 rne"});
    v.push_back('{1'b0, 8'h7E, 7'h00, 2'd0, 1'b0, 16'h0000, 4'b0011, "0.5 rne"});
    v.push_back('{1'b0, 8'h7E, 7'h40, 2'd0, 1'b0, 16'h0001, 4'b0010, "0.75 rne"});
    v.push_back('{1'b0, 8'h01, 7'h00, 2'd3, 1'b0, 16'h0001, 4'b0010, "tiny ceil"});
    v.push_back('{1'b0, 8'h01, 7'h00, 2'd0, 1'b0, 16'h0000, 4'b0011, "tiny rne"});
    v.push_back('{1'b1, 8'h01, 7'h00, 2'd2, 1'b0, 16'hFFFF, 4'b0010, "-tiny floor"});
    foreach (v[i]) begin
      run_word(v[i], d, f, lat);
      n_checks++;
      if (d !== v[i].d) begin n_fail++; $display("FAIL %s dout: got %h want %h", v[i].name, d, v[i].d); end
      n_checks++;
      if (f !== v[i].f) begin n_fail++; $display("FAIL %s flags: got %b want %b", v[i].name, f, v[i].f); end
      n_checks++;
      if (lat !== 4) begin n_fail++; $display("FAIL %s latency: got %0d want 4", v[i].name, lat); end
    end
  endtask

  task automatic test_saturation;
    vec_t v[$];
    logic [15:0] d; logic [3:0] f; int lat;
    v.push_back('{1'b1, 8'h8E, 7'h00, 2'd0, 1'b0, 16'h8000, 4'b0000, "-32768"});
    v.push_back('{1'b0, 8'h8E, 7'h00, 2'd0, 1'b0, 16'h7FFF, 4'b0100, "+32768"});
    v.push_back('{1'b0, 8'h8F, 7'h00, 2'd0, 1'b0, 16'h7FFF, 4'b0100, "65536"});
    v.push_back('{1'b1, 8'hFF, 7'h00, 2'd0, 1'b0, 16'h8000, 4'b0100, "-inf"});
    v.push_back('{1'b0, 8'hFF, 7'h00, 2'd0, 1'b0, 16'h7FFF, 4'b0100, "+inf"});
    v.push_back('{1'b0, 8'hFF, 7'h01, 2'd0, 1'b0, 16'h0000, 4'b1000, "nan"});
    v.push_back('{1'b0, 8'hFE, 7'h00, 2'd0, 1'b0, 16'h7FFF, 4'b0100, "huge"});
    v.push_back('{1'b1, 8'h00, 7'h05, 2'd3, 1'b0, 16'h0000, 4'b0001, "denormal"});
    foreach (v[i]) begin
      run_word(v[i], d, f, lat);
      n_checks++;
      if (d !== v[i].d) begin n_fail++; $display("FAIL %s dout: got %h want %h", v[i].name, d, v[i].d); end
      n_checks++;
      if (f !== v[i].f) begin n_fail++; $display("FAIL %s flags: got %b want %b", v[i].name, f, v[i].f); end
    end
  endtask

  task automatic test_unsigned;
    vec_t v[$];
    logic [15:0] d; logic [3:0] f; int lat;
    // 1.1111111b * 2^15 = 0xFF00
    v.push_back('{1'b0, 8'h8E, 7'h7F, 2'd0, 1'b1, 16'hFF00, 4'b0000, "u 65280"});
    v.push_back('{1'b0, 8'h8E, 7'h00, 2'd0, 1'b1, 16'h8000, 4'b0000, "u 32768"});
    v.push_back('{1'b0, 8'h8F, 7'h00, 2'd0, 1'b1, 16'hFFFF, 4'b0100, "u 65536"});
    v.push_back('{1'b1, 8'h7F, 7'h00, 2'd0, 1'b1, 16'h0000, 4'b0101, "u -1.0"});
    v.push_back('{1'b1, 8'h7D, 7'h00, 2'd1, 1'b1, 16'h0000, 4'b0011, "u -0.25 rtz"});
    v.push_back('{1'b1, 8'h7E, 7'h00, 2'd0, 1'b1, 16'h0000, 4'b0011, "u -0.5 rne"});
    v.push_back('{1'b1, 8'hFF, 7'h00, 2'd0, 1'b1, 16'h0000, 4'b0101, "u -inf"});
    foreach (v[i]) begin
      run_word(v[i], d, f, lat);
      n_checks++;
      if (d !== v[i].d) begin n_fail++; $display("FAIL %s dout: got %h want %h", v[i].name, d, v[i].d); end
      n_checks++;
      if (f !== v[i].f) begin n_fail++; $display("FAIL %s flags: got %b want %b", v[i].name, f, v[i].f); end
    end
  endtask

  task automatic test_stall;
    int cyc = 0;
    sign = 1'b0; exponent = 8'h80; mantissa = 7'h20; rnd_mode = 2'd3; is_unsigned = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (out_valid !== 1'b1 || dout !== 16'h0003) begin
        n_fail++; $display("FAIL stall hold %0d: valid %b dout %h want 1 0003", k, out_valid, dout);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall in_ready %0d: got %b want 0", k, in_ready); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall release: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    vec_t v[$];
    int ii = 0, oi = 0, cyc = 0, extra = 0;
    logic [15:0] held = '0;
    logic was_stalled = 1'b0;
    v.push_back('{1'b0, 8'h7F, 7'h00, 2'd0, 1'b0, 16'h0001, 4'b0000, "b0"});
    v.push_back('{1'b0, 8'h80, 7'h20, 2'd0, 1'b0, 16'h0002, 4'b0010, "b1"});
    v.push_back('{1'b0, 8'h80, 7'h20, 2'd3, 1'b0, 16'h0003, 4'b0010, "b2"});
    v.push_back('{1'b1, 8'h80, 7'h20, 2'd2, 1'b0, 16'hFFFD, 4'b0010, "b3"});
    v.push_back('{1'b0, 8'h85, 7'h48, 2'd1, 1'b0, 16'h0064, 4'b0000, "b4"});
    v.push_back('{1'b1, 8'h81, 7'h60, 2'd0, 1'b0, 16'hFFF9, 4'b0000, "b5"});
    v.push_back('{1'b0, 8'h7E, 7'h40, 2'd0, 1'b0, 16'h0001, 4'b0010, "b6"});
    v.push_back('{1'b0, 8'h86, 7'h7F, 2'd1, 1'b1, 16'h00FF, 4'b0000, "b7"});
    while (oi < 8 && cyc < 300) begin
      in_valid = (ii < 8);
      if (ii < 8) begin
        sign = v[ii].s; exponent = v[ii].e; mantissa = v[ii].m;
        rnd_mode = v[ii].r; is_unsigned = v[ii].u;
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (was_stalled) begin
        n_checks++;
        if (out_valid !== 1'b1 || dout !== held) begin
          n_fail++; $display("FAIL b2b hold: valid %b dout %h want 1 %h", out_valid, dout, held);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (dout !== v[oi].d || flags !== v[oi].f) begin
          n_fail++; $display("FAIL %s: dout %h flags %b want %h %b", v[oi].name, dout, flags, v[oi].d, v[oi].f);
        end
        oi++;
      end
      was_stalled = out_valid && !out_ready;
      held = dout;
      if (in_valid && in_ready) ii++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (oi !== 8) begin n_fail++; $display("FAIL b2b count: got %0d want 8", oi); end
    for (int k = 0; k < 8; k++) begin
      if (out_valid) extra++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL b2b extra outputs: got %0d want 0", extra); end
  endtask

  task automatic test_reset_mid;
    vec_t w;
    logic [15:0] d; logic [3:0] f; int lat;
    int stale = 0;
    out_ready = 1'b1;
    sign = 1'b0; exponent = 8'h80; mantissa = 7'h40; rnd_mode = 2'd0; is_unsigned = 1'b0;
    in_valid = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid reset out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (dout !== 16'h0000 || flags !== 4'b0000) begin
      n_fail++; $display("FAIL mid reset outputs: dout %h flags %b want 0000 0000", dout, flags);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (out_valid) stale++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (stale !== 0) begin n_fail++; $display("FAIL mid reset stale outputs: got %0d want 0", stale); end
    w = '{1'b1, 8'h81, 7'h60, 2'd0, 1'b0, 16'hFFF9, 4'b0000, "post reset"};
    run_word(w, d, f, lat);
    n_checks++;
    if (d !== w.d || lat !== 4) begin
      n_fail++; $display("FAIL post reset word: dout %h lat %0d want %h 4", d, lat, w.d);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sign = 1'b0; exponent = '0; mantissa = '0; rnd_mode = '0; is_unsigned = 1'b0;
    #2;
    test_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_rounding();
    test_saturation();
    test_unsigned();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
